// File: rtl/game_state_controller_pkg.sv
// Shared types and sizes for the game flow controller.
//   game_state_t : internal FSM state (PAUSED only reachable with GAME_PAUSE_EN)
//   STATE_W      : width of the encoded stateOut value
//   FRAME_CNT_W  : width of the frame counters (invulnerability / end screen)
package game_pkg;

    localparam int STATE_W     = 2;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAYING = 3'd1,
        WIN     = 3'd2,
        LOSE    = 3'd3,
        PAUSED  = 3'd4
    } game_state_t;

    // PAUSED is reported as PLAYING on the external state code.
    function automatic logic [STATE_W-1:0] state_code(game_state_t s);
        return (s == PAUSED) ? STATE_W'(1) : s[STATE_W-1:0];
    endfunction

endpackage

// File: rtl/game_state_controller_if.sv
// Signal bundle between the game flow controller and the rest of the screen.
//   master : the surroundings (frame timing, keyboard, collision, life bitmap)
//   slave  : game_state_controller
// Optional: GAME_PAUSE_EN adds pauseKey (in) and freeze (out).
interface game_state_controller_if;
    import game_pkg::*;

    logic               startOfFrame;
    logic               startKey;
    logic               collisionShotPlayer;
    logic               gameLose;
    logic               allAliensDead;
    logic               alienReachedBottom;
    logic               playGame;
    logic               shotHitPlayer;
    logic               playerBlink;
    logic               gameWon;
    logic               gameOver;
    logic [STATE_W-1:0] stateOut;
`ifdef GAME_PAUSE_EN
    logic               pauseKey;
    logic               freeze;
`endif

    modport master (
        output startOfFrame, startKey, collisionShotPlayer, gameLose, allAliensDead, alienReachedBottom,
`ifdef GAME_PAUSE_EN
        output pauseKey, input freeze,
`endif
        input  playGame, shotHitPlayer, playerBlink, gameWon, gameOver, stateOut
    );

    modport slave (
        input  startOfFrame, startKey, collisionShotPlayer, gameLose, allAliensDead, alienReachedBottom,
`ifdef GAME_PAUSE_EN
        input  pauseKey, output freeze,
`endif
        output playGame, shotHitPlayer, playerBlink, gameWon, gameOver, stateOut
    );

endinterface

// File: rtl/game_state_controller_player_hit_filter.sv
// player_hit_filter: turns raw per-pixel shot/player overlap into at most one
// hit per frame, then blanks further hits for INVULN_FRAMES frames.
//   clk, resetN    : clock, synchronous active-low reset
//   en             : game is actively playing (latch/counter live)
//   clr            : zero the invulnerability counter (game leaving to IDLE)
//   startOfFrame   : frame boundary pulse
//   collision      : raw overlap
//   shotHit        : one-cycle accepted-hit pulse
//   playerBlink    : counter bit BLINK_BIT while invulnerable
module player_hit_filter
    import game_pkg::*;
#(
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_BIT     = 2
) (
    input  logic clk,
    input  logic resetN,
    input  logic en,
    input  logic clr,
    input  logic startOfFrame,
    input  logic collision,
    output logic shotHit,
    output logic playerBlink
);

    localparam logic [FRAME_CNT_W-1:0] INV_LOAD = FRAME_CNT_W'(INVULN_FRAMES);

    logic                   hitLatch;
    logic [FRAME_CNT_W-1:0] invulnCnt;
    logic                   hitPulse;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            hitLatch  <= 1'b0;
            invulnCnt <= '0;
            hitPulse  <= 1'b0;
        end else begin
            hitPulse <= 1'b0;
            // The frame start consumes the old latch; a collision on that same
            // cycle seeds the latch for the new frame. Held clear when not enabled.
            hitLatch <= en & (startOfFrame ? collision : (hitLatch | collision));
            if (clr) begin
                invulnCnt <= '0;
            end else if (en && startOfFrame) begin
                if (hitLatch && invulnCnt == '0) begin
                    hitPulse  <= 1'b1;
                    invulnCnt <= INV_LOAD;
                end else if (invulnCnt != '0) begin
                    invulnCnt <= invulnCnt - 1'b1;
                end
            end
        end
    end

    assign shotHit     = hitPulse;
    assign playerBlink = (invulnCnt != '0) && invulnCnt[BLINK_BIT];

endmodule

// File: rtl/game_state_controller.sv
// game_state_controller: top-level game flow FSM (IDLE -> PLAYING -> WIN/LOSE
// -> IDLE) for the space-invaders screen; owns playGame and conditions
// shot/player collisions through player_hit_filter.
//   clk, resetN : clock, synchronous active-low reset
//   bus (slave) : startOfFrame, startKey, collisionShotPlayer, gameLose,
//                 allAliensDead, alienReachedBottom in;
//                 playGame, shotHitPlayer, playerBlink, gameWon, gameOver,
//                 stateOut out
// Optional: define GAME_PAUSE_EN for pauseKey/freeze and the PAUSED state.
module game_state_controller
    import game_pkg::*;
#(
    parameter int INVULN_FRAMES = 60,
    parameter int END_FRAMES    = 120,
    parameter int BLINK_BIT     = 2
) (
    input  logic clk,
    input  logic resetN,
    game_state_controller_if.slave bus
);

    localparam logic [FRAME_CNT_W-1:0] END_LOAD = FRAME_CNT_W'(END_FRAMES);

    game_state_t            state, next_state;
    logic                   startKey_d, keyRise;
    logic [FRAME_CNT_W-1:0] endCnt;
    logic                   hitPulse, blink;
`ifdef GAME_PAUSE_EN
    logic                   pauseKey_d, pauseRise;
`endif

    // State register plus the edge detectors and end-screen counter.
    // Edge registers reload the live key level in reset so that a key held
    // through reset does not look like a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= IDLE;
            startKey_d <= bus.startKey;
            keyRise    <= 1'b0;
            endCnt     <= '0;
        end else begin
            state      <= next_state;
            startKey_d <= bus.startKey;
            keyRise    <= bus.startKey & ~startKey_d;
            if (state == PLAYING && (next_state == WIN || next_state == LOSE))
                endCnt <= END_LOAD;
            else if ((state == WIN || state == LOSE) && bus.startOfFrame && endCnt != '0)
                endCnt <= endCnt - 1'b1;
        end
    end

`ifdef GAME_PAUSE_EN
    always_ff @(posedge clk) begin
        if (!resetN) begin
            pauseKey_d <= bus.pauseKey;
            pauseRise  <= 1'b0;
        end else begin
            pauseKey_d <= bus.pauseKey;
            pauseRise  <= bus.pauseKey & ~pauseKey_d;
        end
    end
`endif

    // Next state. In PLAYING a loss outranks a win.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:
                if (keyRise) next_state = PLAYING;
            PLAYING: begin
                if (bus.alienReachedBottom || bus.gameLose) next_state = LOSE;
                else if (bus.allAliensDead)                 next_state = WIN;
`ifdef GAME_PAUSE_EN
                else if (pauseRise)                         next_state = PAUSED;
`endif
            end
            WIN, LOSE:
                if (keyRise && endCnt == '0) next_state = IDLE;
`ifdef GAME_PAUSE_EN
            PAUSED:
                if (pauseRise) next_state = PLAYING;
`endif
            default:
                next_state = IDLE;
        endcase
    end

    player_hit_filter #(
        .INVULN_FRAMES (INVULN_FRAMES),
        .BLINK_BIT     (BLINK_BIT)
    ) u_hit_filter (
        .clk          (clk),
        .resetN       (resetN),
        .en           (state == PLAYING),
        .clr          (next_state == IDLE),
        .startOfFrame (bus.startOfFrame),
        .collision    (bus.collisionShotPlayer),
        .shotHit      (hitPulse),
        .playerBlink  (blink)
    );

    // Outputs decode registered state only. A pulse produced on the frame the
    // game ends is masked so WIN/LOSE never shows a hit.
    always_comb begin
        bus.playGame      = (state != IDLE);
        bus.gameWon       = (state == WIN);
        bus.gameOver      = (state == LOSE);
        bus.stateOut      = state_code(state);
        bus.shotHitPlayer = hitPulse && (state == PLAYING);
        bus.playerBlink   = blink;
`ifdef GAME_PAUSE_EN
        bus.freeze        = (state == PAUSED);
`endif
    end

endmodule
